// File: rtl/pulse_period_meter.sv
// Rising-edge period meter: reports cycles between successive edges of sig.
// Define PULSE_METER_SYNC_EN to add a two-flop input synchronizer for asynchronous sig.
module pulse_period_meter #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic         sig,
  output logic [N-1:0] period,
  output logic         period_valid,
  output logic         overflow
);

  localparam logic [N-1:0] CNT_MAX = {N{1'b1}};

  typedef enum logic {IDLE, MEASURE} state_t;

  state_t         state, state_next;
  logic [N-1:0]   counter, counter_next, period_next;
  logic           valid_next, ovf_next;
  logic           sig_in, sig_q, rise;

`ifdef PULSE_METER_SYNC_EN
  logic sync1, sync2;

  // Synchronizer resets high so a level already high at reset release is not an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= sig;
      sync2 <= sync1;
    end
  end
  assign sig_in = sync2;
`else
  assign sig_in = sig;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sig_q <= 1'b1;
    else     sig_q <= sig_in;
  end

  assign rise = sig_in & ~sig_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (!ena) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (rise) state_next = MEASURE;
        MEASURE: if (!rise && counter == CNT_MAX) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // The first edge only arms; a timed-out interval drops back to IDLE via overflow.
  always_comb begin
    counter_next = counter;
    period_next  = period;
    valid_next   = 1'b0;
    ovf_next     = 1'b0;
    if (!ena) begin
      counter_next = '0;
    end else begin
      case (state)
        IDLE: begin
          if (rise) counter_next = N'(1);
        end
        MEASURE: begin
          if (rise) begin
            period_next  = counter;
            valid_next   = 1'b1;
            counter_next = N'(1);
          end else if (counter == CNT_MAX) begin
            ovf_next     = 1'b1;
            counter_next = '0;
          end else begin
            counter_next = counter + N'(1);
          end
        end
        default: counter_next = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      counter      <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      counter      <= counter_next;
      period       <= period_next;
      period_valid <= valid_next;
      overflow     <= ovf_next;
    end
  end

endmodule

// File: tb/tb_pulse_period_meter.sv
// Scoreboard bench for pulse_period_meter: edge-timestamp reference model feeds an expected-event queue.
module tb_pulse_period_meter;

  localparam int unsigned N    = 8;
  localparam int          MAXP = (1 << N) - 1;
`ifdef PULSE_METER_SYNC_EN
  localparam bit SYNC = 1'b1;
`else
  localparam bit SYNC = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         ena;
  logic         sig;
  logic [N-1:0] period;
  logic         period_valid;
  logic         overflow;

  pulse_period_meter #(.N(N)) dut (
    .clk(clk), .rst(rst), .ena(ena), .sig(sig),
    .period(period), .period_valid(period_valid), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    bit ovf;
    int per;
  } ev_t;

  ev_t q[$];
  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state: time of the arming edge and sig history seen by the edge detector.
  bit m_armed;
  int m_last;
  int m_last_period;
  bit m_prev, m_d1, m_d2;

  task automatic model_reset();
    m_armed = 1'b0;
    m_last = 0;
    m_last_period = 0;
    m_prev = 1'b1;
    m_d1 = 1'b1;
    m_d2 = 1'b1;
  endtask

  task automatic model_step(input bit s, input bit e);
    bit eff;
    bit r;
    ev_t ev;
    eff = SYNC ? m_d2 : s;
    m_d2 = m_d1;
    m_d1 = s;
    r = eff & ~m_prev;
    m_prev = eff;
    if (!e) begin
      m_armed = 1'b0;
    end else if (r) begin
      if (m_armed) begin
        m_last_period = cyc - m_last;
        ev.cyc = cyc + 1; ev.ovf = 1'b0; ev.per = m_last_period;
        q.push_back(ev);
      end
      m_armed = 1'b1;
      m_last = cyc;
    end else if (m_armed && (cyc - m_last) == MAXP) begin
      ev.cyc = cyc + 1; ev.ovf = 1'b1; ev.per = m_last_period;
      q.push_back(ev);
      m_armed = 1'b0;
    end
  endtask

  task automatic drive_now(input bit s, input bit e);
    sig = s;
    ena = e;
    model_step(s, e);
  endtask

  task automatic apply(input bit s, input bit e);
    @(posedge clk);
    #1;
    drive_now(s, e);
  endtask

  task automatic gap_pulse(input int gap);
    apply(1'b1, 1'b1);
    repeat (gap - 1) apply(1'b0, 1'b1);
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every strobe must match the head of the queue at the predicted cycle.
  always @(negedge clk) begin
    ev_t ev;
    if (period_valid && overflow) begin
      checks++; errors++;
      $display("FAIL both_strobes: valid and overflow high together at cycle %0d", cyc);
    end
    if (period_valid || overflow) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe: valid=%0b ovf=%0b period=%0d cycle %0d, none expected",
                 period_valid, overflow, period, cyc);
      end else begin
        ev = q.pop_front();
        if (ev.cyc != cyc || ev.ovf != overflow || ev.per != int'(period)) begin
          errors++;
          $display("FAIL strobe: cycle=%0d ovf=%0b period=%0d, expected cycle=%0d ovf=%0b period=%0d",
                   cyc, overflow, period, ev.cyc, ev.ovf, ev.per);
        end
      end
    end else if (q.size() != 0 && q[0].cyc <= cyc) begin
      ev = q.pop_front();
      checks++; errors++;
      $display("FAIL missing_strobe: nothing at cycle %0d, expected ovf=%0b period=%0d at cycle %0d",
               cyc, ev.ovf, ev.per, ev.cyc);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int gap;
    int width;
    rst = 1'b1;
    sig = 1'b0;
    ena = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_period", int'(period), 0);
    check("reset_valid", int'(period_valid), 0);
    check("reset_overflow", int'(overflow), 0);
    rst = 1'b0;
    drive_now(1'b0, 1'b0);
    repeat (3) apply(1'b0, 1'b1);

    // Spacing 5, then spacing 2 (toggling), then held high.
    repeat (5) gap_pulse(5);
    repeat (6) gap_pulse(2);
    repeat (20) apply(1'b1, 1'b1);
    repeat (4) apply(1'b0, 1'b1);

    // Timeout: overflow once, then re-arm.
    gap_pulse(300);
    repeat (3) gap_pulse(5);

    // Maximum period exactly.
    gap_pulse(MAXP);
    gap_pulse(10);

    // Enable drop across an edge.
    repeat (3) gap_pulse(5);
    apply(1'b0, 1'b0); apply(1'b1, 1'b0); apply(1'b0, 1'b0);
    apply(1'b0, 1'b1); apply(1'b0, 1'b1);
    repeat (3) gap_pulse(5);
    repeat (10) apply(1'b0, 1'b1);

    // Randomised pulse widths, spacings, long gaps and enable drops.
    for (int i = 0; i < 150; i++) begin
      gap = ($urandom_range(0, 9) == 0) ? int'($urandom_range(250, 262)) : int'($urandom_range(2, 40));
      width = int'($urandom_range(1, gap - 1));
      for (int k = 0; k < gap; k++)
        apply(k < width, $urandom_range(0, 29) != 0);
    end
    repeat (8) apply(1'b0, 1'b1);

    // Asynchronous reset mid-measurement.
    repeat (3) gap_pulse(7);
    apply(1'b0, 1'b1);
    #2 rst = 1'b1;
    q.delete();
    #1;
    check("midrst_period", int'(period), 0);
    check("midrst_valid", int'(period_valid), 0);
    check("midrst_overflow", int'(overflow), 0);
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    model_reset();
    drive_now(1'b0, 1'b1);
    repeat (4) gap_pulse(6);
    repeat (12) apply(1'b0, 1'b1);

    check("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
